// File: rtl/hash_job_mem.sv
// hash_job_mem: SRAM owner and job sequencer for the bitcoin hash core.
// Loads the block header from a host word stream, pulses core_start, serves
// the core's word-addressed memory port, then streams the result words back.
// Optional feature macro: HASH_JOB_MIN_EN adds min_valid/min_word/min_index.
module hash_job_mem #(
  parameter int unsigned MEM_DEPTH  = 256,
  parameter int unsigned MSG_WORDS  = 20,
  parameter int unsigned NUM_NONCES = 16,
  parameter logic [15:0] MSG_BASE   = 16'h0000,
  parameter logic [15:0] OUT_BASE   = 16'h0080
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic        addr_err,
  output logic        core_start,
  input  logic        core_done,
  input  logic        core_mem_we,
  input  logic [15:0] core_mem_addr,
  input  logic [31:0] core_mem_write_data,
  output logic [31:0] core_mem_read_data,
  output logic [15:0] message_addr,
  output logic [15:0] output_addr
`ifdef HASH_JOB_MIN_EN
  ,
  output logic        min_valid,
  output logic [31:0] min_word,
  output logic [7:0]  min_index
`endif
);

  localparam int unsigned AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned LW = (MSG_WORDS > 1) ? $clog2(MSG_WORDS) : 1;
  localparam int unsigned CW = $clog2(NUM_NONCES + 1);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [LW-1:0] r_load_cnt;
  logic [CW-1:0] r_wr_cnt;
  logic [CW-1:0] r_rd_cnt;

  logic [31:0]   r_mem [MEM_DEPTH];

  logic          r_in_ready;
  logic          r_busy;
  logic          r_core_start;
  logic          r_addr_err;
  logic          r_out_valid;
  logic          r_out_last;
  logic [31:0]   r_out_data;
  logic [31:0]   r_core_rdata;

  logic [15:0]   w_host_addr;
  logic [15:0]   w_drain_addr;
  logic [15:0]   w_core_off;
  logic          w_host_ok;
  logic          w_core_ok;
  logic          w_drain_ok;
  logic          w_in_win;
  logic          w_load_last;
  logic          w_wr_full;
  logic          w_fire;
  logic          w_fetch;

  logic          w_mem_we;
  logic [AW-1:0] w_mem_waddr;
  logic [31:0]   w_mem_wdata;

  // Address arithmetic is 16-bit wrapping; range checks happen before indexing.
  assign w_host_addr  = MSG_BASE + 16'(r_load_cnt);
  assign w_drain_addr = OUT_BASE + 16'(r_rd_cnt);
  assign w_core_off   = core_mem_addr - OUT_BASE;
  assign w_host_ok    = 32'(w_host_addr) < MEM_DEPTH;
  assign w_core_ok    = 32'(core_mem_addr) < MEM_DEPTH;
  assign w_drain_ok   = 32'(w_drain_addr) < MEM_DEPTH;
  assign w_in_win     = 32'(w_core_off) < NUM_NONCES;
  assign w_load_last  = (r_load_cnt == LW'(MSG_WORDS - 1));
  assign w_wr_full    = (r_wr_cnt == CW'(NUM_NONCES));

  // Drain handshake: fetch the next word whenever the output register is free.
  assign w_fire  = r_out_valid & out_ready;
  assign w_fetch = (r_state == S_DRAIN) && (r_rd_cnt != CW'(NUM_NONCES)) &&
                   (!r_out_valid || w_fire);

  // Single SRAM write port shared by the host (LOAD) and the core (RUN).
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_waddr = '0;
    w_mem_wdata = '0;
    if (!reset) begin
      if ((r_state == S_LOAD) && in_valid && w_host_ok) begin
        w_mem_we    = 1'b1;
        w_mem_waddr = w_host_addr[AW-1:0];
        w_mem_wdata = in_data;
      end else if ((r_state == S_RUN) && core_mem_we && w_core_ok) begin
        w_mem_we    = 1'b1;
        w_mem_waddr = core_mem_addr[AW-1:0];
        w_mem_wdata = core_mem_write_data;
      end
    end
  end

  // SRAM array; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

  // Core read port: registered, read-before-write, zero when out of range.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_core_rdata <= '0;
    end else begin
      r_core_rdata <= w_core_ok ? r_mem[core_mem_addr[AW-1:0]] : '0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; completion needs both core_done and a full result set.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOAD:  if (in_valid && w_load_last) w_state_nxt = S_START;
      S_START: w_state_nxt = S_RUN;
      S_RUN:   if (core_done && w_wr_full) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_fire && r_out_last) w_state_nxt = S_LOAD;
      default: w_state_nxt = S_LOAD;
    endcase
  end

  // Load, result-write and drain counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_load_cnt <= '0;
      r_wr_cnt   <= '0;
      r_rd_cnt   <= '0;
    end else begin
      if ((r_state == S_LOAD) && in_valid) begin
        r_load_cnt <= w_load_last ? '0 : r_load_cnt + LW'(1);
      end
      if (r_state == S_START) begin
        r_wr_cnt <= '0;
      end else if ((r_state == S_RUN) && core_mem_we && w_core_ok && w_in_win &&
                   !w_wr_full) begin
        r_wr_cnt <= r_wr_cnt + CW'(1);
      end
      if ((r_state == S_RUN) && (w_state_nxt == S_DRAIN)) begin
        r_rd_cnt <= '0;
      end else if (w_fetch) begin
        r_rd_cnt <= r_rd_cnt + CW'(1);
      end
    end
  end

  // Registered status, start pulse, error flag and result stream.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_ready   <= 1'b1;
      r_busy       <= 1'b0;
      r_core_start <= 1'b0;
      r_addr_err   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_out_data   <= '0;
    end else begin
      r_in_ready   <= (w_state_nxt == S_LOAD);
      r_busy       <= (w_state_nxt != S_LOAD);
      r_core_start <= (w_state_nxt == S_START);
      if ((r_state == S_RUN) && !w_core_ok) begin
        r_addr_err <= 1'b1;
      end
      if (w_fetch) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_drain_ok ? r_mem[w_drain_addr[AW-1:0]] : '0;
        r_out_last  <= (r_rd_cnt == CW'(NUM_NONCES - 1));
      end else if (w_fire) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

  assign in_ready           = r_in_ready;
  assign busy               = r_busy;
  assign core_start         = r_core_start;
  assign addr_err           = r_addr_err;
  assign out_valid          = r_out_valid;
  assign out_last           = r_out_last;
  assign out_data           = r_out_data;
  assign core_mem_read_data = r_core_rdata;
  assign message_addr       = MSG_BASE;
  assign output_addr        = OUT_BASE;

`ifdef HASH_JOB_MIN_EN
  logic [7:0]  r_out_idx;
  logic        r_min_have;
  logic        r_min_valid;
  logic [31:0] r_min_word;
  logic [7:0]  r_min_index;

  // Track the smallest transferred word; strict compare keeps the earlier index.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_idx   <= '0;
      r_min_have  <= 1'b0;
      r_min_valid <= 1'b0;
      r_min_word  <= '0;
      r_min_index <= '0;
    end else begin
      if (w_fetch) begin
        r_out_idx <= 8'(r_rd_cnt);
      end
      r_min_valid <= w_fire && r_out_last;
      if ((r_state == S_RUN) && (w_state_nxt == S_DRAIN)) begin
        r_min_have <= 1'b0;
      end else if (w_fire) begin
        r_min_have <= 1'b1;
        if (!r_min_have || (r_out_data < r_min_word)) begin
          r_min_word  <= r_out_data;
          r_min_index <= r_out_idx;
        end
      end
    end
  end

  assign min_valid = r_min_valid;
  assign min_word  = r_min_word;
  assign min_index = r_min_index;
`endif

endmodule

// File: tb/tb_hash_job_mem.sv
// Directed self-checking bench for hash_job_mem (default parameters).
module tb_hash_job_mem;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        addr_err;
  logic        core_start;
  logic        core_done;
  logic        core_mem_we;
  logic [15:0] core_mem_addr;
  logic [31:0] core_mem_write_data;
  logic [31:0] core_mem_read_data;
  logic [15:0] message_addr;
  logic [15:0] output_addr;
`ifdef HASH_JOB_MIN_EN
  logic        min_valid;
  logic [31:0] min_word;
  logic [7:0]  min_index;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] res [16];

  hash_job_mem dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .addr_err(addr_err), .core_start(core_start), .core_done(core_done),
    .core_mem_we(core_mem_we), .core_mem_addr(core_mem_addr),
    .core_mem_write_data(core_mem_write_data), .core_mem_read_data(core_mem_read_data),
    .message_addr(message_addr), .output_addr(output_addr)
`ifdef HASH_JOB_MIN_EN
    , .min_valid(min_valid), .min_word(min_word), .min_index(min_index)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic core_write(input logic [15:0] a, input logic [31:0] d);
    core_mem_we = 1'b1; core_mem_addr = a; core_mem_write_data = d;
    tick();
    core_mem_we = 1'b0; core_mem_addr = 16'h0000; core_mem_write_data = '0;
  endtask

  task automatic write_results(input int lo, input int hi);
    for (int i = lo; i < hi; i++) core_write(16'h0080 + 16'(i), res[i]);
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; core_done = 1'b0;
    core_mem_we = 1'b0; core_mem_addr = '0; core_mem_write_data = '0;
    tick(); tick();
    reset = 1'b0;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %b expected 0", out_last); end
    n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    n_checks++; if (core_start !== 1'b0) begin n_fail++; $display("FAIL reset_core_start: got %b expected 0", core_start); end
    n_checks++; if (core_mem_read_data !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", core_mem_read_data); end
    n_checks++; if (addr_err !== 1'b0) begin n_fail++; $display("FAIL reset_addr_err: got %b expected 0", addr_err); end
    n_checks++; if (message_addr !== 16'h0000) begin n_fail++; $display("FAIL message_addr: got %h expected 0000", message_addr); end
    n_checks++; if (output_addr !== 16'h0080) begin n_fail++; $display("FAIL output_addr: got %h expected 0080", output_addr); end
  endtask

  // Load 20 words base+i with in_valid held high; start must pulse once.
  task automatic load_job(input logic [31:0] base);
    int pulses = 0;
    int not_ready = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = base + 32'(i);
      if (in_ready !== 1'b1) not_ready++;
      if (i < 19 && core_start !== 1'b0) pulses++;
      tick();
    end
    in_valid = 1'b0; in_data = '0;
    if (core_start === 1'b1) pulses++;
    n_checks++; if (not_ready != 0) begin n_fail++; $display("FAIL load_in_ready: got %0d stalled words expected 0", not_ready); end
    n_checks++; if (core_start !== 1'b1) begin n_fail++; $display("FAIL load_start_latency: got %b expected 1", core_start); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL load_in_ready_drop: got %b expected 0", in_ready); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL load_busy: got %b expected 1", busy); end
    tick();
    if (core_start === 1'b1) pulses++;
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL load_start_pulses: got %0d expected 1", pulses); end
  endtask

  task automatic test_core_read();
    core_mem_addr = 16'h0005; tick();
    n_checks++; if (core_mem_read_data !== 32'h5) begin n_fail++; $display("FAIL read_0005: got %h expected 00000005", core_mem_read_data); end
    core_mem_addr = 16'h0013; tick();
    n_checks++; if (core_mem_read_data !== 32'h13) begin n_fail++; $display("FAIL read_0013: got %h expected 00000013", core_mem_read_data); end
    n_checks++; if (addr_err !== 1'b0) begin n_fail++; $display("FAIL addr_err_early: got %b expected 0", addr_err); end
    core_mem_addr = 16'h0100; tick();
    n_checks++; if (core_mem_read_data !== 32'h0) begin n_fail++; $display("FAIL read_0100: got %h expected 0", core_mem_read_data); end
    n_checks++; if (addr_err !== 1'b1) begin n_fail++; $display("FAIL addr_err_set: got %b expected 1", addr_err); end
    core_mem_addr = 16'h0001; tick(); tick();
    n_checks++; if (core_mem_read_data !== 32'h1) begin n_fail++; $display("FAIL read_0001: got %h expected 00000001", core_mem_read_data); end
    n_checks++; if (addr_err !== 1'b1) begin n_fail++; $display("FAIL addr_err_sticky: got %b expected 1", addr_err); end
    core_mem_addr = 16'h0000;
  endtask

  task automatic test_rbw();
    core_mem_we = 1'b1; core_mem_addr = 16'h0005; core_mem_write_data = 32'hDEADBEEF;
    tick();
    core_mem_we = 1'b0;
    n_checks++; if (core_mem_read_data !== 32'h5) begin n_fail++; $display("FAIL rbw_old: got %h expected 00000005", core_mem_read_data); end
    tick();
    n_checks++; if (core_mem_read_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rbw_new: got %h expected deadbeef", core_mem_read_data); end
    core_mem_addr = 16'h0000; core_mem_write_data = '0;
  endtask

  // Wait (bounded) for the first result word after the final result write.
  task automatic wait_first_word(input int max_lat);
    int lat = 0;
    out_ready = 1'b0;
    while (out_valid !== 1'b1 && lat < 8) begin tick(); lat++; end
    n_checks++; if (out_valid !== 1'b1 || lat > max_lat) begin n_fail++; $display("FAIL drain_latency: got %0d cycles valid=%b expected <=%0d", lat, out_valid, max_lat); end
  endtask

  task automatic test_run_gate();
    core_done = 1'b1;
    write_results(0, 15);
    for (int i = 0; i < 4; i++) tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL gate_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL gate_state: got busy=%b in_ready=%b expected 1/0", busy, in_ready); end
    write_results(15, 16);
    wait_first_word(2);
  endtask

  // mode 0: out_ready always high; mode 1: out_ready pattern 1,0,0,1.
  task automatic drain_check(input int mode);
    int idx = 0;
    int cyc = 0;
    int bubbles = 0;
    int stall_bad = 0;
    bit started = 0;
    logic rdy, pv, pl;
    logic [31:0] pd;
    while (idx < 16 && cyc < 100) begin
      rdy = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      out_ready = rdy;
      pv = out_valid; pd = out_data; pl = out_last;
      if (pv === 1'b1) started = 1;
      else if (started) bubbles++;
      tick();
      cyc++;
      if (pv === 1'b1 && rdy) begin
        n_checks++; if (pd !== res[idx] || pl !== (idx == 15)) begin n_fail++; $display("FAIL drain_word%0d: got %h last=%b expected %h last=%b", idx, pd, pl, res[idx], (idx == 15)); end
        idx++;
      end else if (pv === 1'b1) begin
        if (out_valid !== 1'b1 || out_data !== pd || out_last !== pl) stall_bad++;
      end
    end
    out_ready = 1'b0;
    n_checks++; if (idx != 16) begin n_fail++; $display("FAIL drain_count: got %0d transfers expected 16", idx); end
    n_checks++; if (stall_bad != 0) begin n_fail++; $display("FAIL drain_stall_hold: got %0d unstable cycles expected 0", stall_bad); end
    if (mode == 0) begin
      n_checks++; if (bubbles != 0) begin n_fail++; $display("FAIL drain_b2b: got %0d bubbles expected 0", bubbles); end
    end
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL drain_end: got valid=%b in_ready=%b busy=%b expected 0/1/0", out_valid, in_ready, busy); end
`ifdef HASH_JOB_MIN_EN
    n_checks++; if (min_valid !== 1'b1 || min_word !== 32'h10 || min_index !== 8'd1) begin n_fail++; $display("FAIL min_result: got v=%b w=%h i=%0d expected 1/00000010/1", min_valid, min_word, min_index); end
`endif
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_no_extra: got %b expected 0", out_valid); end
`ifdef HASH_JOB_MIN_EN
    n_checks++; if (min_valid !== 1'b0 || min_word !== 32'h10 || min_index !== 8'd1) begin n_fail++; $display("FAIL min_hold: got v=%b w=%h i=%0d expected 0/00000010/1", min_valid, min_word, min_index); end
`endif
  endtask

  task automatic test_back_to_back();
    load_job(32'h0000_0040);
    n_checks++; if (addr_err !== 1'b1) begin n_fail++; $display("FAIL addr_err_job2: got %b expected 1", addr_err); end
    write_results(0, 16);
    wait_first_word(2);
    drain_check(0);
  endtask

  task automatic test_reset_mid_run();
    load_job(32'h0000_0100);
    write_results(0, 4);
    reset = 1'b1; tick(); reset = 1'b0;
    n_checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_state: got in_ready=%b busy=%b expected 1/0", in_ready, busy); end
    n_checks++; if (core_start !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_outs: got start=%b valid=%b expected 0/0", core_start, out_valid); end
    n_checks++; if (addr_err !== 1'b0) begin n_fail++; $display("FAIL midrst_addr_err: got %b expected 0", addr_err); end
    load_job(32'h0000_0200);
    core_mem_addr = 16'h0003; tick();
    n_checks++; if (core_mem_read_data !== 32'h203) begin n_fail++; $display("FAIL job4_read: got %h expected 00000203", core_mem_read_data); end
    core_mem_addr = 16'h0000;
    write_results(0, 16);
    wait_first_word(2);
    drain_check(0);
    n_checks++; if (addr_err !== 1'b0) begin n_fail++; $display("FAIL job4_addr_err: got %b expected 0", addr_err); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) res[i] = 32'h100 + 32'(i);
    res[0] = 32'h50; res[1] = 32'h10; res[2] = 32'h90; res[3] = 32'h10;
    test_reset();
    load_job(32'h0000_0000);
    test_core_read();
    test_rbw();
    test_run_gate();
    drain_check(1);
    test_back_to_back();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
